// File: rtl/fs4_serial.sv
// fs4_serial: bit-serial full subtractor, D = A - B - Bin, LSB first.
// One bit per clock through a single one-bit subtract cell.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request, sampled only while idle
//   a, b   minuend / subtrahend (WIDTH bits)
//   bin    borrow-in
//   busy   high while shifting and during the done cycle
//   done   one-cycle pulse, result valid
//   d      difference (a - b - bin) mod 2^WIDTH, held until next done
//   bout   borrow-out, 1 iff a < b + bin (unsigned)
//   ovf    signed two's-complement overflow of a - b - bin
module fs4_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             a_msb;
  logic             b_msb;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             di;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // One-bit subtract cell on the current LSBs of the operand shift registers.
  always_comb begin
    di       = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    res_next = {di, res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            br     <= bin;
            // Operand MSBs are kept aside because the shift registers
            // lose them before the overflow is evaluated.
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            res_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          res_sh <= res_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            // Publish from the combinational next values so the final bit
            // and final borrow are included on this same edge.
            d     <= res_next;
            bout  <= br_next;
            ovf   <= (a_msb ^ b_msb) & (res_next[WIDTH-1] ^ a_msb);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fs4_serial.sv
// Self-checking bench for fs4_serial: cycle-level behavioural model for the
// 4-bit instance, literal expectations for directed cases, and random
// vectors on an 8-bit instance.
module tb_fs4_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       bin = 1'b0;
  logic       busy, done, bout, ovf;
  logic [3:0] d;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] d8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fs4_serial #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
  );

  fs4_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8), .ovf(ovf8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {ovf, bout, d} with d in the low w bits.
  function automatic logic [9:0] ref_sub(input int w, input int av, input int bv, input int bi);
    int full, sa, sb, r, lo, hi;
    logic [9:0] res;
    full = 1 << w;
    lo = -(full / 2);
    hi = full / 2 - 1;
    sa = (av >= full / 2) ? av - full : av;
    sb = (bv >= full / 2) ? bv - full : bv;
    r = sa - sb - bi;
    res = '0;
    res[7:0] = 8'((av - bv - bi + 2 * full) % full);
    res[8] = (av < bv + bi);
    res[9] = (r < lo) || (r > hi);
    return res;
  endfunction

  // Cycle model: 'since' counts edges after the accepting edge, -1 when idle.
  int         since = -1;
  logic [9:0] pend = '0;
  logic [3:0] m_d = '0;
  logic       m_bout = 1'b0;
  logic       m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      since = -1;
      m_d = '0;
      m_bout = 1'b0;
      m_ovf = 1'b0;
    end else if (since < 0) begin
      if (start) begin
        since = 0;
        pend = ref_sub(4, int'(a), int'(b), int'(bin));
      end
    end else if (since == 4) begin
      since = -1;
    end else begin
      since++;
      if (since == 4) begin
        m_d = pend[3:0];
        m_bout = pend[8];
        m_ovf = pend[9];
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, since >= 0);
    check("done", done, since == 4);
    check("d", d, m_d);
    check("bout", bout, m_bout);
    check("ovf", ovf, m_ovf);
  end

  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin);
    int n;
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb_v; bin = tbin;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 4);
  endtask

  task automatic directed(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                          input logic [3:0] ed, input logic ebo, input logic eov);
    run_op(ta, tb_v, tbin);
    check("dir_d", d, ed);
    check("dir_bout", bout, ebo);
    check("dir_ovf", ovf, eov);
  endtask

  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
    int n;
    logic [9:0] e;
    e = ref_sub(8, int'(ta), int'(tb_v), int'(tbin));
    @(posedge clk); #1;
    start8 = 1'b1; a8 = ta; b8 = tb_v; bin8 = tbin;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8_latency", n, 8);
    check("w8_d", d8, e[7:0]);
    check("w8_bout", bout8, e[8]);
    check("w8_ovf", ovf8, e[9]);
  endtask

  initial begin
    int ndone, last, idx;

    // Reset, then idle with start low.
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("idle_busy", busy, 0);

    // Directed vectors with hand-computed results.
    directed(4'b1110, 4'b0101, 1'b0, 4'b1001, 1'b0, 1'b0);
    directed(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
    directed(4'b0011, 4'b1100, 1'b0, 4'b0111, 1'b1, 1'b0);
    directed(4'b1001, 4'b1110, 1'b1, 4'b1010, 1'b1, 1'b0);
    directed(4'b0010, 4'b1010, 1'b1, 4'b0111, 1'b1, 1'b0);
    directed(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1);

    // Operand hold and start ignored during SHIFT.
    @(posedge clk); #1;
    start = 1'b1; a = 4'b0101; b = 4'b0011; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; a = 4'b1111; b = 4'b0000;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        check("hold_d", d, 4'b0010);
        check("hold_bout", bout, 0);
      end
    end
    check("hold_done_count", ndone, 1);

    // Back-to-back with start held high and fresh operands every cycle.
    @(posedge clk); #1;
    start = 1'b1; a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
    ndone = 0;
    last = -1;
    for (int i = 1; i <= 36; i++) begin
      @(posedge clk); #1;
      a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
      if (done) begin
        if (last >= 0) check("b2b_spacing", i - last, 6);
        last = i;
        ndone++;
      end
    end
    start = 1'b0;
    check("b2b_done_count", ndone, 6);

    // Reset two cycles into SHIFT; previous result is nonzero so the clear is visible.
    run_op(4'b0111, 4'b1000, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a = 4'b0110; b = 4'b0001; bin = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clk); #2 rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("rst_no_done", ndone, 0);
    directed(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);

    // Exhaustive 4-bit sweep against the cycle model.
    for (int i = 0; i < 512; i++) begin
      idx = i;
      run_op(4'(idx >> 5), 4'(idx >> 1), 1'(idx));
    end

    // Random vectors on the 8-bit instance, plus two corner cases.
    run_op8(8'h80, 8'h01, 1'b0);
    run_op8(8'h00, 8'hFF, 1'b1);
    for (int i = 0; i < 40; i++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
